// File: rtl/ram_sync_fill_if.sv
// Bus bundle for ram_sync_fill: write port, read port and the status outputs.
// The master side drives requests; the slave side (the RAM) returns data.
interface ram_sync_fill_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] WAddr;
  logic [DATA_WIDTH-1:0] Din;
  logic                  re;
  logic [ADDR_WIDTH-1:0] RAddr;
  logic [DATA_WIDTH-1:0] Dout;
  logic                  Dvalid;
  logic                  ready;

  modport master (
    output we, WAddr, Din, re, RAddr,
    input  Dout, Dvalid, ready
  );

  modport slave (
    input  we, WAddr, Din, re, RAddr,
    output Dout, Dvalid, ready
  );
endinterface

// File: rtl/ram_sync_fill.sv
// Single-clock RAM that sweeps FILL into every word after reset, then serves
// one write and one registered read per cycle.
// Optional macro RAM_SYNC_FILL_BYPASS_EN: a same-cycle write and read to one
// address returns the new write data instead of the old stored word.
module ram_sync_fill #(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] FILL       = '0
) (
  input logic           clock,
  input logic           reset,  // synchronous, active-low
  ram_sync_fill_if.slave bus_io
);

  localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Next state, memory write port mux (fill sweep vs. user write) and read data.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = FILL;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    unique case (state_q)
      StInit: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (ready_q && bus_io.we) begin
          mem_we    = 1'b1;
          mem_waddr = bus_io.WAddr;
          mem_wdata = bus_io.Din;
        end
        if (ready_q && bus_io.re) begin
          dvalid_d = 1'b1;
          // Read sees the pre-write contents unless forwarding is enabled.
          dout_d   = mem_q[bus_io.RAddr];
`ifdef RAM_SYNC_FILL_BYPASS_EN
          if (bus_io.we && (bus_io.WAddr == bus_io.RAddr)) begin
            dout_d = bus_io.Din;
          end
`endif
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Registered from next state so ready rises on the edge that leaves INIT.
      ready_q  <= (state_d == StRun);
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Storage array; reset does not clear it, only the fill sweep does.
  always_ff @(posedge clock) begin
    if (reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus_io.Dout   = dout_q;
  assign bus_io.Dvalid = dvalid_q;
  assign bus_io.ready  = ready_q;

endmodule

// File: tb/tb_ram_sync_fill.sv
// Bench for ram_sync_fill: two instances (FILL = 0 and FILL = 8'h3C) driven in
// lockstep; a memory model pushes expected read data into per-instance queues
// and each returned word is popped and compared.
module tb_ram_sync_fill;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we, re;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] din;

  ram_sync_fill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  ram_sync_fill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.we = we;  assign bus0.WAddr = waddr;  assign bus0.Din = din;
  assign bus0.re = re;  assign bus0.RAddr = raddr;
  assign bus1.we = we;  assign bus1.WAddr = waddr;  assign bus1.Din = din;
  assign bus1.re = re;  assign bus1.RAddr = raddr;

  ram_sync_fill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL(8'h00)) dut0 (
    .clock  (clk),
    .reset  (rst_n),
    .bus_io (bus0)
  );

  ram_sync_fill #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FILL(8'h3C)) dut1 (
    .clock  (clk),
    .reset  (rst_n),
    .bus_io (bus1)
  );

  always #5 clk = ~clk;

  int unsigned   tests = 0;
  int unsigned   fails = 0;

  logic [DW-1:0] m0 [16];
  logic [DW-1:0] m1 [16];
  bit            mready = 1'b0;
  int unsigned   fcnt = 0;
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge with the inputs currently driven, then compare.
  task automatic cycle();
    bit            acc;
    logic [DW-1:0] e0, e1;
    acc = rst_n && mready && re;
    if (acc) begin
      e0 = m0[raddr];
      e1 = m1[raddr];
`ifdef RAM_SYNC_FILL_BYPASS_EN
      if (we && (waddr == raddr)) begin
        e0 = din;
        e1 = din;
      end
`endif
      q0.push_back(e0);
      q1.push_back(e1);
    end
    if (!rst_n) begin
      mready = 1'b0;
      fcnt   = 0;
      last0  = '0;
      last1  = '0;
    end else if (!mready) begin
      m0[fcnt] = 8'h00;
      m1[fcnt] = 8'h3C;
      if (fcnt == 15) mready = 1'b1;
      fcnt = (fcnt + 1) % 16;
    end else if (we) begin
      m0[waddr] = din;
      m1[waddr] = din;
    end
    @(posedge clk);
    #1;
    check("ready0", 32'(bus0.ready), 32'(mready));
    check("ready1", 32'(bus1.ready), 32'(mready));
    check("dvalid0", 32'(bus0.Dvalid), 32'(acc));
    check("dvalid1", 32'(bus1.Dvalid), 32'(acc));
    if (acc) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        check("sb_empty", 32'(q0.size() + q1.size()), 32'd2);
      end else begin
        last0 = q0.pop_front();
        last1 = q1.pop_front();
        check("dout0", 32'(bus0.Dout), 32'(last0));
        check("dout1", 32'(bus1.Dout), 32'(last1));
      end
    end else begin
      check("hold0", 32'(bus0.Dout), 32'(last0));
      check("hold1", 32'(bus1.Dout), 32'(last1));
    end
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    re = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; waddr = a; din = d; re = 1'b0;
    cycle();
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; raddr = a; we = 1'b0;
    cycle();
    re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; din = '0;
    // Reset for two edges, then the 16-edge fill; requests during fill are ignored.
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i >= 4 && i < 8) begin
        we = 1'b1; waddr = 4'd5; din = 8'hFF; re = 1'b1; raddr = 4'd5;
      end else begin
        we = 1'b0; re = 1'b0;
      end
      cycle();
    end
    we = 1'b0; re = 1'b0;
    check("ready_after_fill", 32'(bus0.ready), 32'd1);

    // Back-to-back reads of every address return FILL.
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; raddr = AW'(i);
      cycle();
    end
    idle(1);

    // Write then read back.
    wr(4'd3, 8'hA5);
    rd(4'd3);
    idle(1);
    rd(4'd5);
    idle(1);

    // Same-cycle write and read to one address.
    wr(4'd7, 8'h11);
    we = 1'b1; waddr = 4'd7; din = 8'h22; re = 1'b1; raddr = 4'd7;
    cycle();
    we = 1'b0;
    rd(4'd7);
    idle(1);

    // Simultaneous write and read to different addresses.
    we = 1'b1; waddr = 4'd9; din = 8'h5A; re = 1'b1; raddr = 4'd3;
    cycle();
    we = 1'b0;
    rd(4'd9);
    idle(1);

    // Writes then a continuous read burst.
    wr(4'd0, 8'd4);
    wr(4'd1, 8'd12);
    wr(4'd2, 8'd6);
    wr(4'd3, 8'd7);
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; raddr = AW'(i);
      cycle();
    end
    idle(1);

    // Reset mid-RUN with a read pending: full refill restores address 15.
    wr(4'd15, 8'h99);
    re = 1'b1; raddr = 4'd15;
    rst_n = 1'b0;
    cycle();
    re = 1'b0;
    rst_n = 1'b1;
    idle(16);
    rd(4'd15);
    idle(1);

    // Reset mid-INIT restarts the sweep from address 0.
    wr(4'd4, 8'h77);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(5);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(16);
    rd(4'd4);
    rd(4'd15);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_sync_fill.md
RAM_SYNC_FILL -- requirements
Module: ram_sync_fill

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, address bits; depth DEPTH = 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-003 The block SHALL have parameter FILL, default 0, DATA_WIDTH-bit value written to every word during initialisation.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-low.
REQ-006 The block SHALL have port we, input, 1 bit, write request.
REQ-007 The block SHALL have port WAddr, input, ADDR_WIDTH bits, write address.
REQ-008 The block SHALL have port Din, input, DATA_WIDTH bits, write data.
REQ-009 The block SHALL have port re, input, 1 bit, read request.
REQ-010 The block SHALL have port RAddr, input, ADDR_WIDTH bits, read address.
REQ-011 The block SHALL have port Dout, output, DATA_WIDTH bits, registered read data.
REQ-012 The block SHALL have port Dvalid, output, 1 bit, one-cycle pulse marking new Dout.
REQ-013 The block SHALL have port ready, output, 1 bit, high when the block accepts requests.

Function
REQ-014 The block SHALL implement a two-state FSM: INIT, RUN.
REQ-015 In INIT the block SHALL write FILL to mem[cnt] each edge, incrementing an ADDR_WIDTH-bit counter cnt from 0.
REQ-016 On the INIT edge with cnt == DEPTH-1 the block SHALL write that last word and move to RUN; cnt wraps to 0.
REQ-017 The block SHALL drive ready as a register equal to (state == RUN); ready goes 1 exactly DEPTH edges after the first edge with reset high.
REQ-018 While ready == 0, the block SHALL ignore we and re: no user write, no Dout change, Dvalid = 0.
REQ-019 With ready == 1 and we == 1, the block SHALL write Din to mem[WAddr] on the edge.
REQ-020 With ready == 1 and re == 1, the block SHALL load Dout on the edge and set Dvalid = 1 for the following cycle: read latency 1.
REQ-021 With re == 0 or ready == 0, the block SHALL hold Dout and clear Dvalid on the edge.
REQ-022 Back-to-back reads SHALL be accepted every cycle; Dvalid stays high while re stays high.
REQ-023 Simultaneous we and re to different addresses SHALL both complete in the same cycle.
REQ-024 For simultaneous we and re to the same address, Dout SHALL follow REQ-030/REQ-031.
REQ-025 Address arithmetic SHALL be unsigned and modulo DEPTH; there is no out-of-range address.

Reset
REQ-026 While reset == 0 at an edge, the block SHALL set state = INIT, cnt = 0, ready = 0, Dout = 0, Dvalid = 0.
REQ-027 Reset asserted mid-INIT or mid-RUN SHALL restart the full fill from address 0; pending requests are dropped.
REQ-028 Memory contents SHALL not be cleared by reset itself; only the INIT sweep overwrites them.

Configuration
REQ-029 Macro RAM_SYNC_FILL_BYPASS_EN SHALL select same-address write-to-read forwarding.
REQ-030 With RAM_SYNC_FILL_BYPASS_EN defined, a same-cycle we/re to one address SHALL return the new Din on Dout.
REQ-031 Without RAM_SYNC_FILL_BYPASS_EN, a same-cycle we/re to one address SHALL return the old stored word; the new word is visible to later reads.

Verification
REQ-032 Defaults; reset low 2 cycles, then high -> ready = 0 for 16 edges, ready = 1 after the 16th; reads of addresses 0..15 return 8'h00.
REQ-033 After ready: write 8'hA5 to 3, then read 3 -> Dout = 8'hA5 with Dvalid = 1 one cycle after the read edge.
REQ-034 During INIT, assert we = 1, WAddr = 5, Din = 8'hFF, re = 1 -> Dvalid stays 0; after ready, read 5 returns 8'h00.
REQ-035 mem[7] = 8'h11; same cycle we to 7 with 8'h22 and re of 7 -> Dout = 8'h22 with bypass, 8'h11 without; next read of 7 returns 8'h22.
REQ-036 FILL = 8'h3C; write 8'h99 to 15; assert reset mid-RUN -> Dout = 0, Dvalid = 0, ready = 0 for 16 edges; read 15 returns 8'h3C.
REQ-037 Continuous re with RAddr 0,1,2,3 after writes 4,12,6,7 -> Dvalid high 4 cycles, Dout = 4,12,6,7 in order.
